// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: decodes control flow, computes target and next PC,
// flags mispredictions and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_ctrl,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_next_pc,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_br, w_is_jal, w_is_jalr;
  logic [XLEN-1:0] w_imm_b, w_imm_j, w_imm_i;
  logic [XLEN-1:0] w_pc4, w_jalr_sum, w_target, w_next_pc;
  logic            w_cond, w_taken, w_mis, w_ctrl;
  logic            w_load, w_hs;

  logic            r_valid, r_ctrl, r_taken, r_mis;
  logic [XLEN-1:0] r_target, r_next_pc;
  logic [CNT_W-1:0] r_bcnt, r_mcnt;

  assign w_opcode  = instruction[6:0];
  assign w_funct3  = instruction[14:12];
  assign w_is_br   = (w_opcode == 7'b1100011);
  assign w_is_jal  = (w_opcode == 7'b1101111);
  assign w_is_jalr = (w_opcode == 7'b1100111) && (w_funct3 == 3'b000);
  assign w_ctrl    = w_is_br | w_is_jal | w_is_jalr;

  assign w_imm_b = {{(XLEN-12){instruction[31]}}, instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-20){instruction[31]}}, instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};
  assign w_imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};

  assign w_pc4      = pc + XLEN'(4);
  assign w_jalr_sum = rs1_data + w_imm_i;

  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      3'b000:  w_cond = (rs1_data == rs2_data);
      3'b001:  w_cond = (rs1_data != rs2_data);
      3'b100:  w_cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  w_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  w_cond = (rs1_data <  rs2_data);
      3'b111:  w_cond = (rs1_data >= rs2_data);
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_target = w_pc4;
    if (w_is_br)        w_target = pc + w_imm_b;
    else if (w_is_jal)  w_target = pc + w_imm_j;
    else if (w_is_jalr) w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
  end

  assign w_taken   = w_is_br ? w_cond : (w_is_jal | w_is_jalr);
  assign w_next_pc = w_taken ? w_target : w_pc4;
  assign w_mis     = (w_taken != pred_taken) || (w_taken && (pred_target != w_target));

  assign in_ready = ~r_valid | out_ready;
  assign w_load   = in_valid & in_ready & ~flush;
  assign w_hs     = r_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= 1'b0;
      r_taken   <= 1'b0;
      r_mis     <= 1'b0;
      r_target  <= '0;
      r_next_pc <= '0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_load)    r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;
      if (w_load) begin
        r_ctrl    <= w_ctrl;
        r_taken   <= w_taken;
        r_mis     <= w_mis;
        r_target  <= w_target;
        r_next_pc <= w_next_pc;
      end
    end
  end

  // Counters account for the result being retired, not the one being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else if (cnt_clear) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else if (w_hs && r_ctrl) begin
      if (!(&r_bcnt))          r_bcnt <= r_bcnt + 1'b1;
      if (r_mis && !(&r_mcnt)) r_mcnt <= r_mcnt + 1'b1;
    end
  end

  assign out_valid        = r_valid;
  assign out_ctrl         = r_ctrl;
  assign out_taken        = r_taken;
  assign out_mispredict   = r_mis;
  assign out_target       = r_target;
  assign out_next_pc      = r_next_pc;
  assign branch_count     = r_bcnt;
  assign mispredict_count = r_mcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus randomized traffic
// checked against a behavioural model of the resolution rules and handshake.
module tb_branch_resolve_unit;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] instruction = '0, pc = '0, rs1_data = '0, rs2_data = '0, pred_target = '0;
  logic pred_taken = 1'b0, flush = 1'b0, out_ready = 1'b0, cnt_clear = 1'b0;
  logic out_valid, out_ctrl, out_taken, out_mispredict;
  logic [31:0] out_target, out_next_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  int n_checks = 0, n_fail = 0;

  // model state
  logic m_valid = 1'b0, m_ctrl = 1'b0, m_taken = 1'b0, m_mis = 1'b0;
  logic [31:0] m_target = '0, m_next = '0;
  int m_bc = 0, m_mc = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_ctrl(out_ctrl),
    .out_taken(out_taken), .out_mispredict(out_mispredict), .out_target(out_target),
    .out_next_pc(out_next_pc), .cnt_clear(cnt_clear), .branch_count(branch_count),
    .mispredict_count(mispredict_count));

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // Reference resolution from the ISA rules, using integer arithmetic.
  function automatic void ref_resolve(input logic [31:0] ins, pc_i, a, b,
                                      input logic pt, input logic [31:0] ptgt,
                                      output logic c, output logic t, output logic m,
                                      output logic [31:0] tgt, output logic [31:0] nxt);
    logic [6:0] op;
    logic [2:0] f3;
    longint imm;
    logic [31:0] s;
    op = ins[6:0];
    f3 = ins[14:12];
    c = 1'b0; t = 1'b0; tgt = pc_i + 32'd4;
    if (op == 7'b1100011) begin
      c = 1'b1;
      imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      tgt = pc_i + 32'(imm);
      case (f3)
        3'd0: t = (a == b);
        3'd1: t = (a != b);
        3'd4: t = ($signed(a) < $signed(b));
        3'd5: t = ($signed(a) >= $signed(b));
        3'd6: t = (a < b);
        3'd7: t = (a >= b);
        default: t = 1'b0;
      endcase
    end else if (op == 7'b1101111) begin
      c = 1'b1; t = 1'b1;
      imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      tgt = pc_i + 32'(imm);
    end else if (op == 7'b1100111 && f3 == 3'd0) begin
      c = 1'b1; t = 1'b1;
      imm = $signed(ins[31:20]);
      s = a + 32'(imm);
      tgt = s - (s % 32'd2);
    end
    nxt = t ? tgt : pc_i + 32'd4;
    m = (t != pt) || (t && ptgt != tgt);
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    logic rdy, hs, ld;
    rdy = !m_valid || out_ready;
    hs  = m_valid && out_ready && !flush;
    ld  = in_valid && rdy && !flush;
    if (cnt_clear) begin
      m_bc = 0; m_mc = 0;
    end else if (hs && m_ctrl) begin
      if (m_bc < CNT_MAX) m_bc++;
      if (m_mis && m_mc < CNT_MAX) m_mc++;
    end
    if (flush) m_valid = 1'b0;
    else if (ld) begin
      ref_resolve(instruction, pc, rs1_data, rs2_data, pred_taken, pred_target,
                  m_ctrl, m_taken, m_mis, m_target, m_next);
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; cnt_clear = 0; out_ready = 1; pred_taken = 0;
    instruction = 32'h13; pred_target = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_checks++; if ({out_ctrl, out_taken, out_mispredict} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {out_ctrl, out_taken, out_mispredict}); end
    n_checks++; if (out_target !== 0 || out_next_pc !== 0) begin n_fail++; $display("FAIL rst_pcs got %h/%h want 0/0", out_target, out_next_pc); end
    n_checks++; if (branch_count !== 0 || mispredict_count !== 0) begin n_fail++; $display("FAIL rst_cnt got %0d/%0d want 0/0", branch_count, mispredict_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1;
    m_valid = 0; m_bc = 0; m_mc = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    idle();
    in_valid = 1; instruction = enc_b(3'b000, 13'd16); pc = 32'h100;
    rs1_data = 5; rs2_data = 5; pred_taken = 0;
    step();
    n_checks++; if (out_taken !== 1'b1 || out_target !== 32'h110 || out_mispredict !== 1'b1) begin n_fail++; $display("FAIL beq got t=%b tgt=%h m=%b want 1/110/1", out_taken, out_target, out_mispredict); end
    instruction = enc_b(3'b100, 13'd8); pc = 32'h200; rs1_data = 32'hFFFF_FFFF; rs2_data = 1;
    step();
    n_checks++; if (branch_count !== 1 || mispredict_count !== 1) begin n_fail++; $display("FAIL beq_cnt got %0d/%0d want 1/1", branch_count, mispredict_count); end
    n_checks++; if (out_taken !== 1'b1 || out_target !== 32'h208) begin n_fail++; $display("FAIL blt got t=%b tgt=%h want 1/208", out_taken, out_target); end
    instruction = enc_b(3'b110, 13'd8);
    step();
    n_checks++; if (out_taken !== 1'b0 || out_next_pc !== 32'h204) begin n_fail++; $display("FAIL bltu got t=%b npc=%h want 0/204", out_taken, out_next_pc); end
    instruction = enc_jalr(12'd4); rs1_data = 32'h1003; pred_taken = 1; pred_target = 32'h1006;
    step();
    n_checks++; if (out_target !== 32'h1006 || out_mispredict !== 1'b0 || out_taken !== 1'b1) begin n_fail++; $display("FAIL jalr got tgt=%h m=%b t=%b want 1006/0/1", out_target, out_mispredict, out_taken); end
    idle(); step();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_tgt;
    idle();
    in_valid = 1; out_ready = 0; instruction = enc_b(3'b001, 13'h1FF0); pc = 32'h400;
    rs1_data = 1; rs2_data = 2;
    step();
    held_tgt = out_target;
    n_checks++; if (out_valid !== 1'b1 || held_tgt !== 32'h3F0) begin n_fail++; $display("FAIL bp_load got v=%b tgt=%h want 1/3f0", out_valid, held_tgt); end
    instruction = enc_jalr(12'd64); rs1_data = 32'h8000;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_target !== held_tgt || out_taken !== 1'b1) begin n_fail++; $display("FAIL bp_hold cyc %0d got v=%b tgt=%h want 1/%h", i, out_valid, out_target, held_tgt); end
    end
    out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
    step();
    n_checks++; if (out_target !== 32'h8040 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next got v=%b tgt=%h want 1/8040", out_valid, out_target); end
    idle(); step();
  endtask

  task automatic test_flush();
    int bc0, mc0;
    idle();
    in_valid = 1; out_ready = 0; instruction = enc_b(3'b000, 13'd4); rs1_data = 3; rs2_data = 3;
    step();
    bc0 = branch_count; mc0 = mispredict_count;
    flush = 1; out_ready = 1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_checks++; if (branch_count !== bc0[CNT_W-1:0] || mispredict_count !== mc0[CNT_W-1:0] || branch_count !== m_bc[CNT_W-1:0]) begin n_fail++; $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", branch_count, mispredict_count, bc0, mc0); end
    idle(); step();
  endtask

  task automatic test_saturation();
    idle(); cnt_clear = 1; step(); cnt_clear = 0;
    in_valid = 1; instruction = enc_b(3'b001, 13'd8); rs1_data = 0; rs2_data = 1; pred_taken = 0;
    for (int i = 0; i < 17; i++) step();
    in_valid = 0; step();
    n_checks++; if (branch_count !== 4'd15 || mispredict_count !== 4'd15) begin n_fail++; $display("FAIL sat got %0d/%0d want 15/15", branch_count, mispredict_count); end
    in_valid = 1; step();
    in_valid = 0; cnt_clear = 1; step(); cnt_clear = 0;
    n_checks++; if (branch_count !== 0 || mispredict_count !== 0) begin n_fail++; $display("FAIL clr_prio got %0d/%0d want 0/0", branch_count, mispredict_count); end
    idle(); step();
  endtask

  task automatic test_random();
    logic [6:0] ops [5] = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b1100111, 7'b0110011};
    for (int i = 0; i < 400; i++) begin
      instruction = $urandom;
      if ($urandom_range(0, 9) != 0) instruction[6:0] = ops[$urandom_range(0, 4)];
      if (instruction[6:0] == 7'b1100111 && $urandom_range(0, 3) != 0) instruction[14:12] = 3'b000;
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      rs1_data = $urandom;
      rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      pred_taken = $urandom_range(0, 1);
      pred_target = ($urandom_range(0, 1) != 0) ? pc + 32'd4 : $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cnt_clear = ($urandom_range(0, 19) == 0);
      #1;
      n_checks++; if (in_ready !== (!m_valid || out_ready)) begin n_fail++; $display("FAIL rnd_in_ready it %0d got %b want %b", i, in_ready, !m_valid || out_ready); end
      step();
      n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid it %0d got %b want %b", i, out_valid, m_valid); end
      n_checks++; if (branch_count !== m_bc[CNT_W-1:0] || mispredict_count !== m_mc[CNT_W-1:0]) begin n_fail++; $display("FAIL rnd_cnt it %0d got %0d/%0d want %0d/%0d", i, branch_count, mispredict_count, m_bc, m_mc); end
      if (m_valid) begin
        n_checks++;
        if ({out_ctrl, out_taken, out_mispredict} !== {m_ctrl, m_taken, m_mis} || out_target !== m_target || out_next_pc !== m_next) begin
          n_fail++;
          $display("FAIL rnd_result it %0d got c%b t%b m%b %h %h want c%b t%b m%b %h %h", i, out_ctrl, out_taken, out_mispredict, out_target, out_next_pc, m_ctrl, m_taken, m_mis, m_target, m_next);
        end
      end
    end
    idle(); step();
  endtask

  task automatic test_reset_midtransfer();
    idle();
    in_valid = 1; out_ready = 0; instruction = enc_b(3'b000, 13'd4); rs1_data = 7; rs2_data = 7;
    step();
    #2; rst_n = 0; #1;
    m_valid = 0; m_bc = 0; m_mc = 0;
    n_checks++; if (out_valid !== 1'b0 || branch_count !== 0) begin n_fail++; $display("FAIL midrst got v=%b bc=%0d want 0/0", out_valid, branch_count); end
    @(negedge clk); rst_n = 1; idle();
    step();
    n_checks++; if (out_valid !== 1'b0 || branch_count !== 0 || mispredict_count !== 0) begin n_fail++; $display("FAIL midrst_idle got v=%b cnt=%0d/%0d want 0/0/0", out_valid, branch_count, mispredict_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    test_reset_midtransfer();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
